// File: rtl/dds_voice_scheduler_if.sv
// Bus bundle between the config/LUT/output side and dds_voice_scheduler.
//   sample_tick : frame request strobe
//   cfg_we/cfg_addr/cfg_ftw/cfg_en : per-voice configuration write
//   phase_out   : registered phase presented to the shared sine LUT
//   sine_in     : LUT sample returned combinationally from phase_out
//   mix_out/mix_valid : mixed sample and its one-cycle strobe
//   busy/overrun : frame-in-progress flag and sticky tick-overrun flag
interface dds_voice_scheduler_if #(
    parameter int unsigned N_VOICES = 4,
    parameter int unsigned ACC_W    = 20,
    parameter int unsigned N        = 14,
    parameter int unsigned M        = 12
);
    localparam int unsigned AW    = $clog2(N_VOICES);
    localparam int unsigned MIX_W = M + $clog2(N_VOICES);

    logic             sample_tick;
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [ACC_W-1:0] cfg_ftw;
    logic             cfg_en;
    logic [N-1:0]     phase_out;
    logic [M-1:0]     sine_in;
    logic [MIX_W-1:0] mix_out;
    logic             mix_valid;
    logic             busy;
    logic             overrun;

    // Front end / LUT / output stage side
    modport master (
        output sample_tick, cfg_we, cfg_addr, cfg_ftw, cfg_en, sine_in,
        input  phase_out, mix_out, mix_valid, busy, overrun
    );

    // Scheduler side
    modport slave (
        input  sample_tick, cfg_we, cfg_addr, cfg_ftw, cfg_en, sine_in,
        output phase_out, mix_out, mix_valid, busy, overrun
    );
endinterface

// File: rtl/dds_voice_scheduler.sv
// Time-multiplexes one shared sine LUT across N_VOICES DDS voices.
// Each sample_tick walks the voices in order (FETCH presents the phase, ACC
// sums the returned sample and advances the accumulator), then DONE emits
// the mixed sample with a one-cycle mix_valid.
//   clk, rst : clock and synchronous active-high reset
//   bus      : dds_voice_scheduler_if.slave (tick, config, LUT and mix signals)
module dds_voice_scheduler #(
    parameter int unsigned N_VOICES = 4,
    parameter int unsigned ACC_W    = 20,
    parameter int unsigned N        = 14,
    parameter int unsigned M        = 12
) (
    input  logic clk,
    input  logic rst,
    dds_voice_scheduler_if.slave bus
);
    localparam int unsigned VW    = $clog2(N_VOICES);
    localparam int unsigned MIX_W = M + $clog2(N_VOICES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ACC   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [VW-1:0]          v;
    logic [ACC_W-1:0]       ftw [N_VOICES];
    logic [ACC_W-1:0]       acc [N_VOICES];
    logic [N_VOICES-1:0]    en;
    logic signed [MIX_W-1:0] mix;

    logic last_voice_c;
    logic signed [MIX_W-1:0] sine_ext_c;

    assign last_voice_c = (v == VW'(N_VOICES - 1));
    assign sine_ext_c   = MIX_W'($signed(bus.sine_in));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.sample_tick) state_next = FETCH;
            FETCH:   state_next = ACC;
            ACC:     state_next = last_voice_c ? DONE : FETCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Voice registers, frame datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N_VOICES); i++) begin
                ftw[i] <= '0;
                acc[i] <= '0;
            end
            en            <= '0;
            v             <= '0;
            mix           <= '0;
            bus.phase_out <= '0;
            bus.mix_out   <= '0;
            bus.mix_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.mix_valid <= 1'b0;

            // A tick outside IDLE is dropped; the running frame is unaffected
            if (bus.sample_tick && (state != IDLE)) begin
                bus.overrun <= 1'b1;
            end

            // Config writes land in the register file only; an ACC in the
            // same cycle still sees the previous ftw/en
            if (bus.cfg_we) begin
                ftw[bus.cfg_addr] <= bus.cfg_ftw;
                en[bus.cfg_addr]  <= bus.cfg_en;
            end

            case (state)
                IDLE: begin
                    if (bus.sample_tick) begin
                        v        <= '0;
                        mix      <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                FETCH: begin
                    bus.phase_out <= acc[v][ACC_W-1 -: N];
                end
                ACC: begin
                    // Disabled voices are parked at phase 0 so re-enable restarts cleanly
                    if (en[v]) begin
                        mix    <= mix + sine_ext_c;
                        acc[v] <= acc[v] + ftw[v];
                    end else begin
                        acc[v] <= '0;
                    end
                    if (!last_voice_c) begin
                        v <= v + VW'(1);
                    end
                end
                DONE: begin
                    bus.mix_out   <= mix;
                    bus.mix_valid <= 1'b1;
                    bus.busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dds_voice_scheduler.sv
// Self-checking bench for dds_voice_scheduler: directed scenarios plus
// randomized frames checked against a per-voice arithmetic reference model.
module tb_dds_voice_scheduler;
    localparam int unsigned N_VOICES = 4;
    localparam int unsigned ACC_W    = 20;
    localparam int unsigned N        = 14;
    localparam int unsigned M        = 12;
    localparam int          LAT      = 2 * N_VOICES + 1;

    logic clk;
    logic rst;

    dds_voice_scheduler_if #(.N_VOICES(N_VOICES), .ACC_W(ACC_W), .N(N), .M(M)) bus ();

    dds_voice_scheduler #(.N_VOICES(N_VOICES), .ACC_W(ACC_W), .N(N), .M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Sine LUT stand-in: either a constant or a scrambled function of phase
    logic         stub_mode;
    logic [M-1:0] stub_val;

    function automatic logic [M-1:0] lut(input logic [N-1:0] p);
        logic [N-1:0] t;
        t = p * 14'd37;
        return t[M-1:0] ^ 12'h5A3;
    endfunction

    function automatic logic [M-1:0] sine_of(input logic [N-1:0] p);
        return stub_mode ? lut(p) : stub_val;
    endfunction

    always_comb bus.sine_in = sine_of(bus.phase_out);

    // Reference model: per-voice configuration and phase accumulators
    logic [ACC_W-1:0] m_ftw [N_VOICES];
    logic [ACC_W-1:0] m_acc [N_VOICES];
    logic             m_en  [N_VOICES];

    logic [N-1:0] last_ph [N_VOICES];
    longint       last_mix;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(N_VOICES); i++) begin
            m_ftw[i] = '0;
            m_acc[i] = '0;
            m_en[i]  = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        check("rst_phase", longint'(bus.phase_out), 0);
        check("rst_mix", longint'(bus.mix_out), 0);
        check("rst_valid", longint'(bus.mix_valid), 0);
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_overrun", longint'(bus.overrun), 0);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic cfg_write(input int a, input logic [ACC_W-1:0] f, input logic e);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 2'(a);
        bus.cfg_ftw  = f;
        bus.cfg_en   = e;
        step();
        bus.cfg_we   = 1'b0;
        m_ftw[a] = f;
        m_en[a]  = e;
    endtask

    task automatic idle_watch(input int n, input string tag);
        int pulses;
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (bus.mix_valid) pulses++;
        end
        check(tag, longint'(pulses), 0);
    endtask

    // One frame. xtick_k>0 injects an extra tick sampled at edge E(xtick_k);
    // wr_k>0 injects a config write sampled at edge E(wr_k), applied to the
    // model after the frame (only used where the write lands on/after its voice's ACC).
    task automatic run_frame(input int xtick_k, input int wr_k, input int wr_a,
                             input logic [ACC_W-1:0] wr_f, input logic wr_e);
        longint       exp_mix;
        logic [N-1:0] exp_ph [N_VOICES];
        int           lat;

        exp_mix = 0;
        for (int i = 0; i < int'(N_VOICES); i++) begin
            exp_ph[i] = m_acc[i][ACC_W-1 -: N];
            if (m_en[i]) begin
                exp_mix  += longint'($signed(sine_of(exp_ph[i])));
                m_acc[i] = m_acc[i] + m_ftw[i];
            end else begin
                m_acc[i] = '0;
            end
        end

        lat = 0;
        bus.sample_tick = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            step();
            if (k == 0) begin
                bus.sample_tick = 1'b0;
                check("busy_start", longint'(bus.busy), 1);
            end
            if ((k % 2 == 1) && (k < 2 * int'(N_VOICES))) last_ph[(k - 1) / 2] = bus.phase_out;
            if (xtick_k > 0 && k == xtick_k - 1) bus.sample_tick = 1'b1;
            if (xtick_k > 0 && k == xtick_k) bus.sample_tick = 1'b0;
            if (wr_k > 0 && k == wr_k - 1) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = 2'(wr_a);
                bus.cfg_ftw  = wr_f;
                bus.cfg_en   = wr_e;
            end
            if (wr_k > 0 && k == wr_k) bus.cfg_we = 1'b0;
            if (bus.mix_valid) begin
                lat = k;
                break;
            end
        end
        bus.sample_tick = 1'b0;
        bus.cfg_we      = 1'b0;
        if (wr_k > 0) begin
            m_ftw[wr_a] = wr_f;
            m_en[wr_a]  = wr_e;
        end

        last_mix = longint'($signed(bus.mix_out));
        check("latency", longint'(lat), longint'(LAT));
        check("mix", last_mix, exp_mix);
        for (int i = 0; i < int'(N_VOICES); i++) begin
            check($sformatf("phase_v%0d", i), longint'(last_ph[i]), longint'(exp_ph[i]));
        end
        step();
        check("valid_pulse", longint'(bus.mix_valid), 0);
        check("busy_end", longint'(bus.busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.sample_tick = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_addr    = '0;
        bus.cfg_ftw     = '0;
        bus.cfg_en      = 1'b0;
        stub_mode       = 1'b0;
        stub_val        = '0;
        step();

        // Reset state
        do_reset();

        // Single voice, constant LUT, phase walks 0,1,2
        stub_val = 12'h123;
        cfg_write(0, 20'h00040, 1'b1);
        for (int f = 0; f < 3; f++) begin
            run_frame(0, 0, 0, '0, 1'b0);
            check("t2_mix", last_mix, 64'sh123);
            check("t2_phase", longint'(last_ph[0]), longint'(f));
        end

        // All voices at full-scale positive and negative
        for (int i = 0; i < int'(N_VOICES); i++) cfg_write(i, 20'($urandom), 1'b1);
        stub_val = 12'h7FF;
        run_frame(0, 0, 0, '0, 1'b0);
        check("t3_max", last_mix, 8188);
        stub_val = 12'h800;
        run_frame(0, 0, 0, '0, 1'b0);
        check("t3_min", last_mix, -8192);

        // Half-cycle FTW wraps the accumulator
        do_reset();
        cfg_write(0, 20'h80000, 1'b1);
        stub_val = 12'h001;
        run_frame(0, 0, 0, '0, 1'b0);
        check("t4_ph0", longint'(last_ph[0]), 64'h0000);
        run_frame(0, 0, 0, '0, 1'b0);
        check("t4_ph1", longint'(last_ph[0]), 64'h2000);
        run_frame(0, 0, 0, '0, 1'b0);
        check("t4_ph2", longint'(last_ph[0]), 64'h0000);

        // Overrun: tick mid-frame, exactly one mix_valid
        do_reset();
        cfg_write(0, 20'h01000, 1'b1);
        run_frame(3, 0, 0, '0, 1'b0);
        idle_watch(12, "t5_extra_valid");
        check("t5_overrun", longint'(bus.overrun), 1);
        // Overrun from a tick during DONE
        do_reset();
        cfg_write(2, 20'h00800, 1'b1);
        run_frame(9, 0, 0, '0, 1'b0);
        idle_watch(12, "t5_done_extra_valid");
        check("t5_done_overrun", longint'(bus.overrun), 1);

        // Reset mid-frame aborts it
        do_reset();
        cfg_write(0, 20'h02000, 1'b1);
        run_frame(0, 0, 0, '0, 1'b0);
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_clear();
        idle_watch(12, "t6_abort_valid");
        check("t6_busy", longint'(bus.busy), 0);
        check("t6_phase", longint'(bus.phase_out), 0);
        cfg_write(0, 20'h02000, 1'b1);
        run_frame(0, 0, 0, '0, 1'b0);
        check("t6_restart", longint'(last_ph[0]), 0);

        // Config write to v1 during v1's ACC cycle (edge E4)
        stub_mode = 1'b1;
        cfg_write(1, 20'h01000, 1'b1);
        run_frame(0, 4, 1, 20'h03000, 1'b1);
        run_frame(0, 0, 0, '0, 1'b0);
        check("t6_old_ftw", longint'(last_ph[1]), 64'h40);
        run_frame(0, 0, 0, '0, 1'b0);
        check("t6_new_ftw", longint'(last_ph[1]), 64'h100);

        // Randomized frames against the model
        do_reset();
        for (int f = 0; f < 30; f++) begin
            int nw;
            nw = int'($urandom_range(0, 2));
            for (int w = 0; w < nw; w++) begin
                cfg_write(int'($urandom_range(0, N_VOICES - 1)), 20'($urandom),
                          1'($urandom_range(0, 3) != 0));
            end
            stub_mode = 1'($urandom);
            stub_val  = 12'($urandom);
            run_frame(0, 0, 0, '0, 1'b0);
        end
        check("rand_no_overrun", longint'(bus.overrun), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
